// File: rtl/matmul_pkg.sv
// Shared definitions for the DIMxDIM matrix multiplier: default dimensions,
// derived width helpers and the MAC-stage state encoding. The address
// generators import this package as well.
package matmul_pkg;

   localparam int DIM_DEF = 3;
   localparam int DW_DEF  = 8;

   // Address width for a DIM*DIM element RAM (at least one bit).
   function automatic int calc_aw(input int dim);
      return (dim * dim > 1) ? $clog2(dim * dim) : 1;
   endfunction

   // Accumulator width: full product plus growth for DIM terms.
   function automatic int calc_accw(input int dw, input int dim);
      return 2 * dw + ((dim > 1) ? $clog2(dim) : 0);
   endfunction

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_ADDR = 3'd1,
      ST_READ      = 3'd2,
      ST_MAC       = 3'd3,
      ST_WRITE     = 3'd4,
      ST_DONE      = 3'd5
   } mm_state_e;

endpackage

// File: rtl/matmul_mac_stage_mac_acc.sv
// Multiply-add datapath with accumulator register.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   clr_i      zero the accumulator (wins over en_i)
//   en_i       acc <= acc + a_i*b_i
//   a_i, b_i   unsigned operands
//   sum_o      acc + a_i*b_i (combinational, for capture by the caller)
module mac_acc #(
   parameter int DW   = 8,
   parameter int ACCW = 18
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr_i,
   input  logic            en_i,
   input  logic [DW-1:0]   a_i,
   input  logic [DW-1:0]   b_i,
   output logic [ACCW-1:0] sum_o
);

   logic [ACCW-1:0] acc_q;
   logic [ACCW-1:0] prod;

   assign prod  = ACCW'(a_i) * ACCW'(b_i);
   assign sum_o = acc_q + prod;

   always_ff @(posedge clk) begin
      if (rst)        acc_q <= '0;
      else if (clr_i) acc_q <= '0;
      else if (en_i)  acc_q <= sum_o;
   end

endmodule

// File: rtl/matmul_mac_stage.sv
// MAC consumer stage of the matrix multiplier. Pairs A/B operand addresses
// from the generators, reads both operand RAMs, accumulates DIM products per
// C element and writes C row-major.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    begin a product (IDLE only)
//   a_/b_addr_valid, _addr   address strobes from the generators
//   gen_ena                  generator enable (WAIT_ADDR only)
//   a_/b_rd_en, _rd_addr     operand RAM reads; _rd_data one cycle later
//   c_wr_en/addr/data        result RAM write
//   busy, done, addr_ovf     status
//
// state     | meaning
// IDLE      | waiting for start
// WAIT_ADDR | collecting one A and one B address
// READ      | operand RAM read strobes
// MAC       | operand data valid, accumulate
// WRITE     | write finished dot product to C
// DONE      | one-cycle done pulse
module matmul_mac_stage
   import matmul_pkg::*;
#(
   parameter int DIM  = DIM_DEF,
   parameter int DW   = DW_DEF,
   parameter int AW   = calc_aw(DIM),
   parameter int ACCW = calc_accw(DW, DIM)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            a_addr_valid,
   input  logic [AW-1:0]   a_addr,
   input  logic            b_addr_valid,
   input  logic [AW-1:0]   b_addr,
   output logic            gen_ena,
   output logic            a_rd_en,
   output logic [AW-1:0]   a_rd_addr,
   input  logic [DW-1:0]   a_rd_data,
   output logic            b_rd_en,
   output logic [AW-1:0]   b_rd_addr,
   input  logic [DW-1:0]   b_rd_data,
   output logic            c_wr_en,
   output logic [AW-1:0]   c_wr_addr,
   output logic [ACCW-1:0] c_wr_data,
   output logic            busy,
   output logic            done,
   output logic            addr_ovf
);

   localparam int KW = (DIM > 1) ? $clog2(DIM) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(DIM - 1);
   localparam logic [AW-1:0] C_LAST = AW'(DIM * DIM - 1);

   mm_state_e       state_q, state_d;
   logic            a_full_q, a_full_d, b_full_q, b_full_d;
   logic [AW-1:0]   a_hold_q, a_hold_d, b_hold_q, b_hold_d;
   logic            ovf_q, ovf_d;
   logic [KW-1:0]   k_q, k_d;
   logic [AW-1:0]   c_idx_q, c_idx_d;
   logic            acc_clr, acc_en;
   logic [ACCW-1:0] acc_sum;
   logic [AW-1:0]   ra_nxt, rb_nxt;

   logic            gen_ena_q, a_rd_en_q, b_rd_en_q, c_wr_en_q, busy_q, done_q;
   logic [AW-1:0]   a_rd_addr_q, b_rd_addr_q, c_wr_addr_q;
   logic [ACCW-1:0] c_wr_data_q;

   always_comb begin
      state_d  = state_q;
      a_full_d = a_full_q;
      b_full_d = b_full_q;
      a_hold_d = a_hold_q;
      b_hold_d = b_hold_q;
      ovf_d    = ovf_q;
      k_d      = k_q;
      c_idx_d  = c_idx_q;
      acc_clr  = 1'b0;
      acc_en   = 1'b0;
      ra_nxt   = '0;
      rb_nxt   = '0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               acc_clr = 1'b1;
               k_d     = '0;
               c_idx_d = '0;
               ovf_d   = 1'b0;
               state_d = ST_WAIT_ADDR;
            end
         end
         ST_WAIT_ADDR: begin
            if (a_addr_valid) begin
               if (a_full_q) ovf_d = 1'b1;
               else begin
                  a_hold_d = a_addr;
                  a_full_d = 1'b1;
               end
            end
            if (b_addr_valid) begin
               if (b_full_q) ovf_d = 1'b1;
               else begin
                  b_hold_d = b_addr;
                  b_full_d = 1'b1;
               end
            end
            // A strobe completing the pair goes straight to READ on the
            // same edge; its address bypasses the holding register.
            if (a_full_d && b_full_d) begin
               a_full_d = 1'b0;
               b_full_d = 1'b0;
               ra_nxt   = a_full_q ? a_hold_q : a_addr;
               rb_nxt   = b_full_q ? b_hold_q : b_addr;
               state_d  = ST_READ;
            end
         end
         ST_READ: state_d = ST_MAC;
         ST_MAC: begin
            acc_en = 1'b1;
            if (k_q == K_LAST) state_d = ST_WRITE;
            else begin
               k_d     = k_q + 1'b1;
               state_d = ST_WAIT_ADDR;
            end
         end
         ST_WRITE: begin
            acc_clr = 1'b1;
            k_d     = '0;
            if (c_idx_q == C_LAST) state_d = ST_DONE;
            else begin
               c_idx_d = c_idx_q + 1'b1;
               state_d = ST_WAIT_ADDR;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         a_full_q    <= 1'b0;
         b_full_q    <= 1'b0;
         a_hold_q    <= '0;
         b_hold_q    <= '0;
         ovf_q       <= 1'b0;
         k_q         <= '0;
         c_idx_q     <= '0;
         gen_ena_q   <= 1'b0;
         a_rd_en_q   <= 1'b0;
         b_rd_en_q   <= 1'b0;
         a_rd_addr_q <= '0;
         b_rd_addr_q <= '0;
         c_wr_en_q   <= 1'b0;
         c_wr_addr_q <= '0;
         c_wr_data_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_full_q    <= a_full_d;
         b_full_q    <= b_full_d;
         a_hold_q    <= a_hold_d;
         b_hold_q    <= b_hold_d;
         ovf_q       <= ovf_d;
         k_q         <= k_d;
         c_idx_q     <= c_idx_d;
         // Outputs are registered from the next state so they line up
         // with the state they belong to.
         gen_ena_q   <= (state_d == ST_WAIT_ADDR);
         a_rd_en_q   <= (state_d == ST_READ);
         b_rd_en_q   <= (state_d == ST_READ);
         a_rd_addr_q <= ra_nxt;
         b_rd_addr_q <= rb_nxt;
         c_wr_en_q   <= (state_d == ST_WRITE);
         c_wr_addr_q <= (state_d == ST_WRITE) ? c_idx_q : '0;
         c_wr_data_q <= (state_d == ST_WRITE) ? acc_sum : '0;
         busy_q      <= (state_d != ST_IDLE);
         done_q      <= (state_d == ST_DONE);
      end
   end

   mac_acc #(.DW(DW), .ACCW(ACCW)) u_mac_acc (
      .clk   (clk),
      .rst   (rst),
      .clr_i (acc_clr),
      .en_i  (acc_en),
      .a_i   (a_rd_data),
      .b_i   (b_rd_data),
      .sum_o (acc_sum)
   );

   assign gen_ena   = gen_ena_q;
   assign a_rd_en   = a_rd_en_q;
   assign b_rd_en   = b_rd_en_q;
   assign a_rd_addr = a_rd_addr_q;
   assign b_rd_addr = b_rd_addr_q;
   assign c_wr_en   = c_wr_en_q;
   assign c_wr_addr = c_wr_addr_q;
   assign c_wr_data = c_wr_data_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign addr_ovf  = ovf_q;

endmodule
